// File: rtl/stopwatch_seg_display.sv
// MM.SS four-digit common-anode display driver: double-dabble BCD conversion of minute/second
// counts plus digit scanning. Define LEAD_ZERO_BLANK_EN to blank a leading zero in the minute tens.
module stopwatch_seg_display #(
   parameter int SCAN_DIV = 1000,
   parameter int SCAN_W   = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] sec_val,
   input  logic [6:0] min_val,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, CONV_SEC, CONV_MIN, LOAD} state_t;

`ifdef LEAD_ZERO_BLANK_EN
   localparam logic BLANK_MIN_TENS = 1'b1;
`else
   localparam logic BLANK_MIN_TENS = 1'b0;
`endif

   localparam logic [3:0] CODE_DASH  = 4'hE;
   localparam logic [3:0] CODE_BLANK = 4'hF;

   state_t      state_reg;
   logic        first_reg;
   logic        busy_reg;
   logic [6:0]  sec_snap_reg;
   logic [6:0]  min_snap_reg;
   logic [18:0] dd_reg;
   logic [18:0] dd_next;
   logic [11:0] bcd_adj;
   logic [2:0]  bit_cnt_reg;
   logic [11:0] sec_bcd_reg;
   logic [3:0]  dig_reg [4];

   logic [SCAN_W-1:0] presc_reg;
   logic [1:0]        idx_reg;
   logic [6:0]        seg_reg;
   logic [3:0]        an_reg;
   logic [3:0]        an_next;
   logic              dp_reg;

   // Shift register layout: {hundreds, tens, ones, binary[6:0]}; adjust then shift once per cycle
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] = (dd_reg[7 + gi*4 +: 4] >= 4'd5) ?
                                     dd_reg[7 + gi*4 +: 4] + 4'd3 :
                                     dd_reg[7 + gi*4 +: 4];
      end
   endgenerate

   assign dd_next = {bcd_adj[10:0], dd_reg[6:0], 1'b0};

   // Returns {tens, ones}; an overrange pair shows dashes in both places
   function automatic logic [7:0] pair_digits(input logic [11:0] bcd, input logic blank_lead);
      logic [7:0] res;
      if (bcd[11:8] != 4'd0)
         res = {CODE_DASH, CODE_DASH};
      else if (blank_lead && (bcd[7:4] == 4'd0))
         res = {CODE_BLANK, bcd[3:0]};
      else
         res = bcd[7:0];
      return res;
   endfunction

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         4'hE:    s = 7'b0111111;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         first_reg    <= 1'b1;
         busy_reg     <= 1'b0;
         sec_snap_reg <= 7'd0;
         min_snap_reg <= 7'd0;
         dd_reg       <= 19'd0;
         bit_cnt_reg  <= 3'd0;
         sec_bcd_reg  <= 12'd0;
         for (int i = 0; i < 4; i++) dig_reg[i] <= 4'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (first_reg || ({min_val, sec_val} != {min_snap_reg, sec_snap_reg})) begin
                  sec_snap_reg <= sec_val;
                  min_snap_reg <= min_val;
                  first_reg    <= 1'b0;
                  dd_reg       <= {12'd0, sec_val};
                  bit_cnt_reg  <= 3'd0;
                  busy_reg     <= 1'b1;
                  state_reg    <= CONV_SEC;
               end
            end
            CONV_SEC: begin
               if (bit_cnt_reg == 3'd6) begin
                  // Park the seconds result and reuse the shift register for minutes
                  sec_bcd_reg <= dd_next[18:7];
                  dd_reg      <= {12'd0, min_snap_reg};
                  bit_cnt_reg <= 3'd0;
                  state_reg   <= CONV_MIN;
               end else begin
                  dd_reg      <= dd_next;
                  bit_cnt_reg <= bit_cnt_reg + 3'd1;
               end
            end
            CONV_MIN: begin
               dd_reg <= dd_next;
               if (bit_cnt_reg == 3'd6) begin
                  bit_cnt_reg <= 3'd0;
                  state_reg   <= LOAD;
               end else begin
                  bit_cnt_reg <= bit_cnt_reg + 3'd1;
               end
            end
            LOAD: begin
               {dig_reg[1], dig_reg[0]} <= pair_digits(sec_bcd_reg, 1'b0);
               {dig_reg[3], dig_reg[2]} <= pair_digits(dd_reg[18:7], BLANK_MIN_TENS);
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   generate
      for (gi = 0; gi < 4; gi++) begin : g_an
         assign an_next[gi] = (idx_reg != 2'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_reg <= '0;
         idx_reg   <= 2'd0;
         seg_reg   <= 7'b1111111;
         an_reg    <= 4'b1111;
         dp_reg    <= 1'b1;
      end else begin
         if (presc_reg == SCAN_W'(SCAN_DIV - 1)) begin
            presc_reg <= '0;
            idx_reg   <= idx_reg + 2'd1;
         end else begin
            presc_reg <= presc_reg + SCAN_W'(1);
         end
         // Colon sits between minutes and seconds, lit with the minute ones digit
         seg_reg <= seg_code(dig_reg[idx_reg]);
         an_reg  <= an_next;
         dp_reg  <= (idx_reg != 2'd2);
      end
   end

   assign seg  = seg_reg;
   assign an   = an_reg;
   assign dp   = dp_reg;
   assign busy = busy_reg;

endmodule

// File: tb/tb_stopwatch_seg_display.sv
// Randomized bench for stopwatch_seg_display, compared each cycle against a
// timing-level model built from decimal arithmetic on the applied minute/second values.
module tb_stopwatch_seg_display;

   localparam int SCAN_DIV = 4;
   localparam int SCAN_W   = 3;
   localparam int CONV_LAT = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] sec_val = 7'd0;
   logic [6:0] min_val = 7'd0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic       busy;

   int total_cnt = 0;
   int bad_cnt   = 0;

   // model state
   int  m_edges;
   int  m_left;
   bit  m_first;
   int  m_snap_s;
   int  m_snap_m;
   int  m_dig [4];
   logic [6:0] seg_lut [16];

   stopwatch_seg_display #(.SCAN_DIV(SCAN_DIV), .SCAN_W(SCAN_W)) dut (
      .clk(clk), .rst(rst), .sec_val(sec_val), .min_val(min_val),
      .seg(seg), .dp(dp), .an(an), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [12:0] got, input logic [12:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s at %0t: got busy/dp/an/seg=%b required=%b", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_edges  = 0;
      m_left   = 0;
      m_first  = 1'b1;
      m_snap_s = 0;
      m_snap_m = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = 0;
   endtask

   task automatic model_load();
      if (m_snap_s > 99) begin
         m_dig[0] = 14; m_dig[1] = 14;
      end else begin
         m_dig[0] = m_snap_s % 10; m_dig[1] = m_snap_s / 10;
      end
      if (m_snap_m > 99) begin
         m_dig[2] = 14; m_dig[3] = 14;
      end else begin
         m_dig[2] = m_snap_m % 10; m_dig[3] = m_snap_m / 10;
`ifdef LEAD_ZERO_BLANK_EN
         if (m_dig[3] == 0) m_dig[3] = 15;
`endif
      end
   endtask

   // One clock edge: advance the model with the inputs seen at that edge and compare
   task automatic step(input string tag);
      logic r;
      int s, m, idx;
      logic [3:0] e_an;
      logic       e_dp;
      logic [6:0] e_seg;
      logic [12:0] exp;
      @(posedge clk);
      r = rst;
      s = int'(sec_val);
      m = int'(min_val);
      #1;
      if (r) begin
         model_reset();
         exp = {1'b0, 1'b1, 4'b1111, 7'b1111111};
      end else begin
         m_edges++;
         idx   = ((m_edges - 1) / SCAN_DIV) % 4;
         e_seg = seg_lut[m_dig[idx]];
         e_an  = ~(4'b0001 << idx);
         e_dp  = (idx != 2);
         if (m_left == 0) begin
            if (m_first || s != m_snap_s || m != m_snap_m) begin
               m_snap_s = s;
               m_snap_m = m;
               m_first  = 1'b0;
               m_left   = CONV_LAT;
            end
         end else begin
            m_left--;
            if (m_left == 0) model_load();
         end
         exp = {(m_left != 0), e_dp, e_an, e_seg};
      end
      check_val(tag, {busy, dp, an, seg}, exp);
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic apply(input int s, input int m);
      sec_val = 7'(s);
      min_val = 7'(m);
      $display("apply sec=%0d min=%0d at %0t", s, m, $time);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      check_val("rst_async", {busy, dp, an, seg}, {1'b0, 1'b1, 4'b1111, 7'b1111111});
      #1;
      step("rst_edge");
      rst = 1'b0;
      $display("reset pulse at %0t", $time);
   endtask

   initial begin
      int s, m;
      seg_lut[0]  = 7'b1000000; seg_lut[1]  = 7'b1111001;
      seg_lut[2]  = 7'b0100100; seg_lut[3]  = 7'b0110000;
      seg_lut[4]  = 7'b0011001; seg_lut[5]  = 7'b0010010;
      seg_lut[6]  = 7'b0000010; seg_lut[7]  = 7'b1111000;
      seg_lut[8]  = 7'b0000000; seg_lut[9]  = 7'b0010000;
      for (int i = 10; i < 16; i++) seg_lut[i] = 7'b1111111;
      seg_lut[14] = 7'b0111111;
      model_reset();

      run("reset", 3);
      rst = 1'b0;
      $display("reset released at %0t", $time);
      run("first_conv", 40);

      apply(7, 0);   run("sec7", 25);
      apply(45, 0);  run("sec45", 25);
      apply(59, 59); run("mm59ss59", 25);

      apply(10, 59); run("sec10", 10);
      apply(11, 59); run("sec11_late", 40);

      apply(120, 59); run("sec120", 25);

      apply(30, 3);  run("pre_rst", 3);
      pulse_reset();
      run("post_rst", 40);

      for (int k = 0; k < 60; k++) begin
         s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 59));
         m = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 59));
         apply(s, m);
         run("rand", int'($urandom_range(1, 24)));
         if ($urandom_range(0, 11) == 0) begin
            pulse_reset();
            run("rand_rst", int'($urandom_range(1, 10)));
         end
      end
      run("drain", 40);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
